// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and size/crossing helpers for the data-memory access stage
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_t;

    // Encoding 2'b11 falls into the default arm and behaves as a word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size_t'(size))
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_crossing(input logic [1:0] offset, input logic [1:0] size);
        return ({1'b0, offset} + byte_count(size)) > 3'd4;
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// rtl/byte_lane_ram.sv - single-port word RAM with per-byte write enables and registered read
module byte_lane_ram #(
    parameter int WORD_ADDR_WIDTH = 15,
    parameter int WORD_LENGTH     = 32,
    parameter int BYTE_LEN        = 8
) (
    input  logic                       clk,
    input  logic [WORD_ADDR_WIDTH-1:0] addr,
    input  logic [3:0]                 be,
    input  logic [WORD_LENGTH-1:0]     wdata,
    output logic [WORD_LENGTH-1:0]     rdata
);

    logic [WORD_LENGTH-1:0] mem [0:(1 << WORD_ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][i*BYTE_LEN +: BYTE_LEN] <= wdata[i*BYTE_LEN +: BYTE_LEN];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_access.sv
// rtl/data_mem_access.sv - byte/half/word load-store stage with split beats for word-crossing accesses
module data_mem_access
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int WORD_LENGTH = 32,
    parameter int BYTE_LEN    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   we,
    input  logic [1:0]             size,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [WORD_LENGTH-1:0] wdata,
    output logic                   rsp_valid,
    output logic [WORD_LENGTH-1:0] rdata_word,
    output logic [BYTE_LEN-1:0]    rdata_byte
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    state_t                 state, state_nx;
    logic                   accept;
    logic                   we_q;
    logic [1:0]             size_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [WORD_LENGTH-1:0] wdata_q;
    logic [2:0]             count;
    logic                   crossing;
    logic [IDX_W-1:0]       word_idx;
    logic [IDX_W-1:0]       ram_addr;
    logic [3:0]             be0, be1, ram_be;
    logic [WORD_LENGTH-1:0] wd0, wd1, ram_wdata, ram_rdata;
    logic [WORD_LENGTH-1:0] beat0_q, lo_word, resp_data, rdata_q;
    logic [2:0]             wr_lane, rd_lane;

    assign req_ready = ((state == IDLE) || (state == RESP)) && !rst;
    assign accept    = req_valid && req_ready;
    assign count     = byte_count(size_q);
    assign crossing  = is_crossing(addr_q[1:0], size_q);
    assign word_idx  = addr_q[ADDR_WIDTH-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= we;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == RESP) begin
                rdata_q <= resp_data;
            end
        end
    end

    // During BEAT1 the RAM output still holds the beat-0 word; keep it for assembly in RESP.
    always_ff @(posedge clk) begin
        if (state == BEAT1) begin
            beat0_q <= ram_rdata;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? BEAT0 : IDLE;
            BEAT0:   state_nx = crossing ? BEAT1 : RESP;
            BEAT1:   state_nx = RESP;
            RESP:    state_nx = accept ? BEAT0 : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request byte j lands on lane offset+j; lanes 4..7 belong to the next word.
    always_comb begin
        be0     = '0;
        be1     = '0;
        wd0     = '0;
        wd1     = '0;
        wr_lane = '0;
        for (int j = 0; j < 4; j++) begin
            wr_lane = {1'b0, addr_q[1:0]} + 3'(j);
            if (3'(j) < count) begin
                if (wr_lane[2]) begin
                    be1[wr_lane[1:0]] = 1'b1;
                    wd1[wr_lane[1:0]*BYTE_LEN +: BYTE_LEN] = wdata_q[j*BYTE_LEN +: BYTE_LEN];
                end else begin
                    be0[wr_lane[1:0]] = 1'b1;
                    wd0[wr_lane[1:0]*BYTE_LEN +: BYTE_LEN] = wdata_q[j*BYTE_LEN +: BYTE_LEN];
                end
            end
        end
    end

    assign ram_addr  = (state == BEAT1) ? word_idx + IDX_W'(1) : word_idx;
    assign ram_wdata = (state == BEAT1) ? wd1 : wd0;

    always_comb begin
        ram_be = '0;
        if (!rst && we_q) begin
            if (state == BEAT0) ram_be = be0;
            if (state == BEAT1) ram_be = be1;
        end
    end

    byte_lane_ram #(
        .WORD_ADDR_WIDTH(IDX_W),
        .WORD_LENGTH    (WORD_LENGTH),
        .BYTE_LEN       (BYTE_LEN)
    ) u_ram (
        .clk  (clk),
        .addr (ram_addr),
        .be   (ram_be),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign lo_word = crossing ? beat0_q : ram_rdata;

    always_comb begin
        resp_data = '0;
        rd_lane   = '0;
        for (int j = 0; j < 4; j++) begin
            rd_lane = {1'b0, addr_q[1:0]} + 3'(j);
            if (!we_q && (3'(j) < count)) begin
                resp_data[j*BYTE_LEN +: BYTE_LEN] = rd_lane[2]
                    ? ram_rdata[rd_lane[1:0]*BYTE_LEN +: BYTE_LEN]
                    : lo_word[rd_lane[1:0]*BYTE_LEN +: BYTE_LEN];
            end
        end
    end

    assign rsp_valid  = (state == RESP);
    assign rdata_word = (state == RESP) ? resp_data : rdata_q;
    assign rdata_byte = rdata_word[BYTE_LEN-1:0];

endmodule

// File: tb/tb_data_mem_access.sv
// tb/tb_data_mem_access.sv - self-checking bench for data_mem_access
module tb_data_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [16:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rsp_valid;
    logic [31:0] rdata_word;
    logic [7:0]  rdata_byte;

    data_mem_access #(
        .ADDR_WIDTH (17),
        .WORD_LENGTH(32),
        .BYTE_LEN   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .we        (we),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rdata_word(rdata_word),
        .rdata_byte(rdata_byte)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic [16:0] a;
        logic [31:0] d;
        logic [31:0] e;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected rsp_valid", 32'd1, 32'd0);
            end else begin
                check("rdata_word", rdata_word, sb[0].data);
                check("rdata_byte", {24'h0, rdata_byte}, {24'h0, sb[0].data[7:0]});
                check("rsp latency", 32'(cyc), sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic add(input logic w, input logic [1:0] s, input logic [16:0] a,
                       input logic [31:0] d, input logic [31:0] e, input int lat);
        vec_t v;
        v.w = w; v.s = s; v.a = a; v.d = d; v.e = e; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic issue(input logic w, input logic [1:0] s, input logic [16:0] a,
                         input logic [31:0] d, input logic [31:0] e, input int lat,
                         output int t_acc);
        int waited = 0;
        req_valid = 1'b1; we = w; size = s; addr = a; wdata = d;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept timeout: req_ready %b after %0d cycles, expected 1", req_ready, waited);
        end
        t_acc = cyc;
        sb.push_back('{e, 32'(cyc + lat)});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int t_acc[4];

        repeat (3) @(negedge clk);
        check("reset req_ready", {31'h0, req_ready}, 32'd0);
        check("reset rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("reset rdata_word", rdata_word, 32'h0);
        check("reset rdata_byte", {24'h0, rdata_byte}, 32'h0);
        rst = 1'b0;
        #1;
        check("ready after reset", {31'h0, req_ready}, 32'd1);
        @(negedge clk);

        add(1, 2'b10, 17'h00100, 32'hDEADBEEF, 32'h0,        2);
        add(0, 2'b00, 17'h00100, 32'h0,        32'h000000EF, 2);
        add(0, 2'b00, 17'h00101, 32'h0,        32'h000000BE, 2);
        add(0, 2'b00, 17'h00102, 32'h0,        32'h000000AD, 2);
        add(0, 2'b00, 17'h00103, 32'h0,        32'h000000DE, 2);
        add(0, 2'b01, 17'h00102, 32'h0,        32'h0000DEAD, 2);
        add(0, 2'b01, 17'h00101, 32'h0,        32'h0000ADBE, 2);
        add(0, 2'b10, 17'h00100, 32'h0,        32'hDEADBEEF, 2);
        add(1, 2'b10, 17'h00100, 32'h11223344, 32'h0,        2);
        add(1, 2'b00, 17'h00102, 32'hFFFFFF80, 32'h0,        2);
        add(0, 2'b10, 17'h00100, 32'h0,        32'h11803344, 2);
        add(1, 2'b10, 17'h001FC, 32'hAABBCCDD, 32'h0,        2);
        add(1, 2'b10, 17'h00200, 32'h44332211, 32'h0,        2);
        add(1, 2'b10, 17'h00204, 32'hCAFEF00D, 32'h0,        2);
        add(0, 2'b10, 17'h001FF, 32'h0,        32'h332211AA, 3);
        add(0, 2'b01, 17'h001FE, 32'h0,        32'h0000AABB, 2);
        add(0, 2'b01, 17'h001FF, 32'h0,        32'h000011AA, 3);
        add(0, 2'b10, 17'h001FE, 32'h0,        32'h2211AABB, 3);
        add(0, 2'b10, 17'h001FD, 32'h0,        32'h11AABBCC, 3);
        add(1, 2'b01, 17'h00203, 32'hFFFF9988, 32'h0,        3);
        add(0, 2'b10, 17'h00200, 32'h0,        32'h88332211, 2);
        add(0, 2'b10, 17'h00204, 32'h0,        32'hCAFEF099, 2);
        add(0, 2'b00, 17'h00203, 32'h0,        32'h00000088, 2);
        add(0, 2'b11, 17'h00201, 32'h0,        32'h99883322, 3);
        add(1, 2'b11, 17'h00300, 32'h12345678, 32'h0,        2);
        add(0, 2'b10, 17'h00300, 32'h0,        32'h12345678, 2);
        add(1, 2'b10, 17'h1FFFC, 32'h01020304, 32'h0,        2);
        add(1, 2'b10, 17'h00000, 32'h05060708, 32'h0,        2);
        add(1, 2'b01, 17'h1FFFF, 32'h00005A6B, 32'h0,        3);
        add(0, 2'b10, 17'h1FFFC, 32'h0,        32'h6B020304, 2);
        add(0, 2'b10, 17'h00000, 32'h0,        32'h0506075A, 2);
        add(0, 2'b01, 17'h1FFFF, 32'h0,        32'h00005A6B, 3);
        add(0, 2'b00, 17'h1FFFE, 32'h0,        32'h00000002, 2);
        add(0, 2'b00, 17'h00001, 32'h0,        32'h00000007, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d, vecs[i].e, vecs[i].lat, t);
        end
        drain();

        issue(0, 2'b10, 17'h00100, 32'h0, 32'h11803344, 2, t_acc[0]);
        issue(0, 2'b10, 17'h001FC, 32'h0, 32'hAABBCCDD, 2, t_acc[1]);
        issue(0, 2'b10, 17'h00200, 32'h0, 32'h88332211, 2, t_acc[2]);
        issue(0, 2'b10, 17'h00204, 32'h0, 32'hCAFEF099, 2, t_acc[3]);
        for (int i = 1; i < 4; i++) begin
            check("back-to-back accept spacing", 32'(t_acc[i] - t_acc[i-1]), 32'd2);
        end
        drain();

        repeat (3) @(negedge clk);
        check("rdata_word held", rdata_word, 32'hCAFEF099);

        req_valid = 1'b1; we = 1'b0; size = 2'b10; addr = 17'h00100;
        @(negedge clk);
        req_valid = 1'b0;
        check("ready low in BEAT0", {31'h0, req_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid-beat reset rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("mid-beat reset rdata_word", rdata_word, 32'h0);
        check("mid-beat reset rdata_byte", {24'h0, rdata_byte}, 32'h0);
        check("mid-beat reset req_ready", {31'h0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready after mid-beat reset", {31'h0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);

        issue(0, 2'b10, 17'h00100, 32'h0, 32'h11803344, 2, t);
        drain();
        repeat (3) @(negedge clk);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_access.md
# data_mem_access

Byte-addressed data-memory access stage of the RISC-V core. It sits between the memory pipeline stage and the load extenders. It accepts one load or store per handshake and performs byte/half/word accesses on a word-organised RAM, little-endian. Misaligned accesses that cross a word boundary are split into two RAM beats. It returns right-justified, zero-filled load data; `rdata_byte` feeds `byte_extend` directly, and sign extension happens downstream.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: byte-address width (128 KiB data memory).
- `WORD_LENGTH`, 32: data word width.
- `BYTE_LEN`, 8: byte width.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- `addr`  in  ADDR_WIDTH  byte address.
- `wdata`  in  WORD_LENGTH  store data, right-justified.
- `rsp_valid`  out  1  one-cycle completion pulse for loads and stores.
- `rdata_word`  out  WORD_LENGTH  load result, zero-filled above `size`.
- `rdata_byte`  out  BYTE_LEN  `rdata_word[7:0]`.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- `req_ready` = (state is IDLE or RESP) and not `rst`. A request is accepted when `req_valid` and `req_ready` are both high. Acceptance latches `we`, `size`, `addr`, `wdata` and moves to BEAT0.
- Beat 0 uses word index `addr[ADDR_WIDTH-1:2]` with byte lanes starting at `addr[1:0]`.
- A request is crossing when `addr[1:0]` + bytes(size) > 4. Crossing cases:
  - half at offset 3;
  - word at offsets 1, 2 or 3.
- Beat 1 uses word index + 1 for the remaining lanes, starting at lane 0.
- Word index wraps from its maximum value to 0 with no error.
- Transitions:
  - BEAT0 goes to BEAT1 if the request is crossing, otherwise to RESP.
  - BEAT1 goes to RESP.
  - RESP goes to BEAT0 on acceptance, otherwise to IDLE.
- Stores write only the enabled byte lanes. Other lanes and other words are unchanged.
- Loads assemble bytes little-endian, lowest address into bits [7:0]. Bits above the access size are 0.
- For stores, `rdata_word` is 0 in RESP.
- Outputs are held until the next RESP.
- RAM contents are not reset and are not initialised by this block.
- Reset in any state:
  - returns to IDLE on the next edge;
  - clears `rsp_valid` and `rdata_word`;
  - drops the latched request.
- Reset after beat 0 of a crossing store leaves the beat-0 lanes written and the beat-1 lanes unwritten. This partial write is accepted behaviour.
- `req_valid` while `req_ready` is low is ignored. The requester must hold the request.

## Timing
- Reset values: `req_ready` 0 while `rst` is high, then 1 in the first cycle after reset. `rsp_valid` 0. `rdata_word` 0. `rdata_byte` 0.
- Request accepted in cycle t:
  - non-crossing: `rsp_valid` high in cycle t+2;
  - crossing: `rsp_valid` high in cycle t+3.
- `rsp_valid` is high for exactly one cycle per request.
- The RAM read is synchronous. The address is presented in a beat cycle and the data is registered at the end of that cycle.
- Stores commit at the end of each beat cycle.
- Back-to-back non-crossing requests give one completion every 2 cycles, because acceptance in RESP is allowed.
- A store immediately followed by a load of the same address returns the new data. The store completes before the load's BEAT0, so no forwarding is needed.

## Structure
- Package `mem_pkg` holds:
  - `size_t` enum (`SIZE_B`, `SIZE_H`, `SIZE_W`);
  - `state_t` enum;
  - the function computing byte count and the crossing flag.
- Sub-module `byte_lane_ram`:
  - 2^(ADDR_WIDTH-2) words of WORD_LENGTH bits;
  - 4 byte write enables;
  - synchronous read;
  - single port.
- The top level contains the FSM, lane alignment, write-enable generation and read assembly.

## Test plan
- Reset mid-BEAT0 of a load → next cycle IDLE, `rsp_valid` 0, `rdata_word` 0, `req_ready` 1 once `rst` falls.
- Store word 0xDEADBEEF at 0x100, then load bytes 0x100..0x103 → 0xEF, 0xBE, 0xAD, 0xDE on `rdata_byte`, with `rdata_word` upper bits 0. Each response arrives at t+2.
- Store byte 0x80 at 0x102 over the word 0x11223344 at 0x100 → load word at 0x100 returns 0x11803344.
- Crossing word load at 0x1FF, after storing 0xAABBCCDD at 0x1FC and 0x44332211 at 0x200 → `rdata_word` 0x332211AA at t+3.
- Crossing half store 0x5A6B at 0x1FFFF (top byte of memory) → address 0x1FFFF = 0x6B and address 0x00000 = 0x5A after wrap; neighbouring bytes unchanged.
- Hold `req_valid` with 4 aligned loads back-to-back → accepted every 2 cycles, 4 `rsp_valid` pulses, and requests presented while `req_ready` is low are neither dropped nor duplicated.
